vga_timing_gen: RTL and testbench

- Downstream consumer of the 25.175 MHz pixel clock and its MMCM `locked` status.
- Generates 640x480@60 Hz VGA timing: hsync, vsync, data-enable, pixel coordinates, and line/frame strobes for the pixel pipeline.
- Holds all timing idle until the clock is reported locked.
- Stops and restarts cleanly if lock is lost.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 Hz VGA timing generator.
// Sync indices are in counter terms: hsync spans h_cnt 656..751, vsync spans v_cnt 490..491.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vga_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous status inputs.
// Reset clears both stages to 0, so q lags d by two clock edges.
module sync_2ff (
  input  logic clk_in1,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in1) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator gated by the synchronised MMCM lock status.
// Counters run only in RUN; every RUN entry restarts a full frame at (0,0).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk_in1,
  input  logic               reset,
  input  logic               locked,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               line_start,
  output logic               frame_start,
  output logic               running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic                locked_s;
  vga_state_e          state_q;
  vga_state_e          state_d;
  logic                run_en_p0;
  logic [COORD_W-1:0]  h_cnt;
  logic [COORD_W-1:0]  v_cnt;
  logic                de_p0;
  logic                hs_act_p0;
  logic                vs_act_p0;

  sync_2ff u_lock_sync (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .d       (locked),
    .q       (locked_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (locked_s)  state_d = RUN;
      RUN:     if (!locked_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters and outputs advance only while RUN is held; losing lock clears them on the exit edge.
  assign run_en_p0 = (state_q == RUN) && locked_s;

  always_ff @(posedge clk_in1) begin
    if (!reset || !run_en_p0) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign de_p0     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_act_p0 = (h_cnt >= HS_START) && (h_cnt <= HS_END);
  assign vs_act_p0 = (v_cnt >= VS_START) && (v_cnt <= VS_END);

  // Output register stage: one cycle behind the counters.
  always_ff @(posedge clk_in1) begin
    if (!reset || !run_en_p0) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      hsync       <= hs_act_p0 ? HS_POL : ~HS_POL;
      vsync       <= vs_act_p0 ? VS_POL : ~VS_POL;
      de          <= de_p0;
      pix_x       <= de_p0 ? h_cnt : '0;
      pix_y       <= de_p0 ? v_cnt : '0;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      running     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-timing instance so whole
// frames fit in a short run; both are compared every cycle against an arithmetic model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic locked = 1'b0;
  always #20 clk = ~clk;

  int ha  [2] = '{640, 16};
  int hfp [2] = '{16, 4};
  int hsw [2] = '{96, 6};
  int hbp [2] = '{48, 6};
  int va  [2] = '{480, 12};
  int vfp [2] = '{10, 2};
  int vsw [2] = '{2, 2};
  int vbp [2] = '{33, 3};

  logic [1:0] hs, vs, de, ls_o, fs_o, run_o;
  logic [9:0] px [2];
  logic [9:0] py [2];

  vga_timing_gen u_full (
    .clk_in1(clk), .reset(reset), .locked(locked),
    .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .pix_x(px[0]), .pix_y(py[0]),
    .line_start(ls_o[0]), .frame_start(fs_o[0]), .running(run_o[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk_in1(clk), .reset(reset), .locked(locked),
    .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .pix_x(px[1]), .pix_y(py[1]),
    .line_start(ls_o[1]), .frame_start(fs_o[1]), .running(run_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: lock seen two edges late, RUN one edge after that, outputs show the
  // position (age in clocks since RUN entry) one edge later still.
  bit m_started = 0;
  bit m_l1 = 0, m_ls = 0, m_run = 0, m_oen = 0;
  int m_age = 0, m_oage = 0;

  always @(posedge clk) begin
    m_started = 1;
    if (!reset) begin
      m_l1 = 0; m_ls = 0; m_run = 0; m_age = 0; m_oen = 0; m_oage = 0;
    end else begin
      m_oen  = m_run && m_ls;
      m_oage = m_age;
      m_age  = (m_run && m_ls) ? m_age + 1 : 0;
      m_run  = m_ls;
      m_ls   = m_l1;
      m_l1   = locked;
    end
  end

  function automatic logic [25:0] expect_vec(int i);
    int ht, vt, h, v;
    bit de_e, hsa, vsa;
    ht = ha[i] + hfp[i] + hsw[i] + hbp[i];
    vt = va[i] + vfp[i] + vsw[i] + vbp[i];
    h = m_oage % ht;
    v = (m_oage / ht) % vt;
    de_e = m_oen && (h < ha[i]) && (v < va[i]);
    hsa  = m_oen && (h >= ha[i] + hfp[i]) && (h < ha[i] + hfp[i] + hsw[i]);
    vsa  = m_oen && (v >= va[i] + vfp[i]) && (v < va[i] + vfp[i] + vsw[i]);
    return {~hsa, ~vsa, de_e, de_e ? 10'(h) : 10'd0, de_e ? 10'(v) : 10'd0,
            m_oen && h == 0, m_oen && h == 0 && v == 0, m_oen};
  endfunction

  // Measurement state for the literal timing checks.
  int cyc = 0;
  int a_ls1 = -1, a_ls2 = -1, a_hsf = -1, a_hsr = -1, a_de_n = 0, a_px_bad = 0;
  int b_fs1 = -1, b_fs2 = -1, b_vsf = -1, b_vsr = -1, b_delines = 0;
  logic [19:0] b_last = '0;
  logic a_hs_prev = 1'b1, b_vs_prev = 1'b1;

  always @(negedge clk) begin
    if (m_started) begin
      cyc++;
      chk("full_model",  32'({hs[0], vs[0], de[0], px[0], py[0], ls_o[0], fs_o[0], run_o[0]}), 32'(expect_vec(0)));
      chk("small_model", 32'({hs[1], vs[1], de[1], px[1], py[1], ls_o[1], fs_o[1], run_o[1]}), 32'(expect_vec(1)));

      if (ls_o[0]) begin
        if (a_ls1 < 0) a_ls1 = cyc;
        else if (a_ls2 < 0) a_ls2 = cyc;
      end
      if (a_ls1 >= 0 && a_ls2 < 0 && de[0]) begin
        a_de_n++;
        if (int'(px[0]) != cyc - a_ls1) a_px_bad++;
      end
      if (a_ls1 >= 0 && a_hsf < 0 && !hs[0] && a_hs_prev) a_hsf = cyc;
      if (a_hsf >= 0 && a_hsr < 0 && hs[0] && !a_hs_prev) a_hsr = cyc;
      a_hs_prev = hs[0];

      if (fs_o[1]) begin
        if (b_fs1 < 0) b_fs1 = cyc;
        else if (b_fs2 < 0) b_fs2 = cyc;
      end
      if (b_fs1 >= 0 && b_fs2 < 0) begin
        if (de[1]) b_last = {px[1], py[1]};
        if (de[1] && ls_o[1]) b_delines++;
        if (b_vsf < 0 && !vs[1] && b_vs_prev) b_vsf = cyc;
        if (b_vsf >= 0 && b_vsr < 0 && vs[1] && !b_vs_prev) b_vsr = cyc;
      end
      b_vs_prev = vs[1];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    locked = 1'b1;
    repeat (5) tick();
    chk("rst_hsync",   32'(hs),    32'h3);
    chk("rst_vsync",   32'(vs),    32'h3);
    chk("rst_de",      32'(de),    32'h0);
    chk("rst_running", 32'(run_o), 32'h0);
    chk("rst_pulses",  32'({ls_o, fs_o}), 32'h0);
    chk("rst_pix",     32'({px[0], py[0]}), 32'h0);

    // Lock already high; reset release makes the next edge "edge k".
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("acq_early_running", 32'(run_o), 32'h0);
      chk("acq_early_fs",      32'(fs_o),  32'h0);
    end
    tick();
    chk("acq_running", 32'(run_o), 32'h3);
    chk("acq_fs",      32'(fs_o),  32'h3);
    chk("acq_de",      32'(de),    32'h3);
    chk("acq_pix",     32'({px[0], py[0], px[1], py[1]}), 32'h0);

    repeat (1700) tick();

    // Lock loss: outputs still active after k and k+1, back to reset values after k+2.
    locked = 1'b0;
    tick();
    chk("loss_k0_running", 32'(run_o), 32'h3);
    tick();
    chk("loss_k1_running", 32'(run_o), 32'h3);
    tick();
    chk("loss_k2_running", 32'(run_o), 32'h0);
    chk("loss_k2_sync",    32'({hs, vs}), 32'hF);
    chk("loss_k2_de",      32'(de), 32'h0);
    repeat (5) tick();
    locked = 1'b1;
    repeat (3) tick();
    chk("relock_early_fs", 32'(fs_o), 32'h0);
    tick();
    chk("relock_fs",  32'(fs_o), 32'h3);
    chk("relock_pix", 32'({px[0], py[0], px[1], py[1]}), 32'h0);

    repeat (300) tick();

    // One-clock reset in mid-frame, then the same restart latency as a fresh acquire.
    reset = 1'b0;
    tick();
    chk("midrst_running", 32'(run_o), 32'h0);
    chk("midrst_sync",    32'({hs, vs}), 32'hF);
    chk("midrst_de",      32'(de), 32'h0);
    reset = 1'b1;
    repeat (3) tick();
    chk("midrst_early_running", 32'(run_o), 32'h0);
    tick();
    chk("midrst_running_back", 32'(run_o), 32'h3);
    chk("midrst_fs",           32'(fs_o),  32'h3);

    repeat (700) tick();

    chk("line_period",     32'(a_ls2 - a_ls1), 32'd800);
    chk("hsync_offset",    32'(a_hsf - a_ls1), 32'd656);
    chk("hsync_width",     32'(a_hsr - a_hsf), 32'd96);
    chk("de_per_line",     32'(a_de_n),        32'd640);
    chk("pix_x_ramp_errs", 32'(a_px_bad),      32'd0);
    chk("frame_period",    32'(b_fs2 - b_fs1), 32'd608);
    chk("vsync_offset",    32'(b_vsf - b_fs1), 32'd448);
    chk("vsync_width",     32'(b_vsr - b_vsf), 32'd64);
    chk("de_lines",        32'(b_delines),     32'd12);
    chk("last_pixel",      32'(b_last),        32'({10'd15, 10'd11}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
